// File: rtl/mux_gate_arbiter_if.sv
// rtl/mux_gate_arbiter_if.sv - request/operand/grant/result bundle for mux_gate_arbiter
interface mux_gate_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] op_a;
   logic [NUM_REQ*WIDTH-1:0] op_b;
   logic [NUM_REQ-1:0]       op_sel;
   logic [NUM_REQ-1:0]       grant;
   logic                     busy;
   logic                     done;
   logic [ID_W-1:0]          done_id;
   logic [WIDTH-1:0]         result;

   modport slave (
      input  req, op_a, op_b, op_sel,
      output grant, busy, done, done_id, result
   );

   modport master (
      output req, op_a, op_b, op_sel,
      input  grant, busy, done, done_id, result
   );
endinterface

// File: rtl/mux_2_1.sv
// rtl/mux_2_1.sv - 2:1 multiplexer primitive, the only gate the bit-serial slice is built from
module mux_2_1 (
   input  logic d0_i,
   input  logic d1_i,
   input  logic s_i,
   output logic y_o
);
   assign y_o = s_i ? d1_i : d0_i;
endmodule

// File: rtl/mux_gate_arbiter.sv
// rtl/mux_gate_arbiter.sv - round-robin arbiter sharing one bit-serial XOR/XNOR mux slice
// Winner's operands are latched and shifted LSB-first; result is returned with a one-cycle done.
module mux_gate_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mux_gate_arbiter_if.slave    bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [ID_W-1:0]    PTR_RST  = ID_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    done_id_q, done_id_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    idx;
   logic               winner_vld;
   logic               b_n;
   logic               bit_a0;
   logic               bit_a1;
   logic               slice_bit;

   // Slice: inverter mux, polarity muxes for a=0 / a=1, then a selects between them.
   mux_2_1 u_inv  (.d0_i(1'b1),      .d1_i(1'b0),      .s_i(b_sh_q[0]), .y_o(b_n));
   mux_2_1 u_pol0 (.d0_i(b_sh_q[0]), .d1_i(b_n),       .s_i(sel_q),     .y_o(bit_a0));
   mux_2_1 u_pol1 (.d0_i(b_n),       .d1_i(b_sh_q[0]), .s_i(sel_q),     .y_o(bit_a1));
   mux_2_1 u_xsel (.d0_i(bit_a0),    .d1_i(bit_a1),    .s_i(a_sh_q[0]), .y_o(slice_bit));

   // Descending scan so the closest set bit after ptr is the last (winning) assignment.
   always_comb begin
      winner     = '0;
      winner_vld = 1'b0;
      idx        = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (bus.req[idx]) begin
            winner     = idx;
            winner_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      done_id_d = done_id_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      acc_d     = acc_q;
      result_d  = result_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (winner_vld) begin
               grant_d = ONE_HOT0 << winner;
               ptr_d   = winner;
               a_sh_d  = bus.op_a[int'(winner)*WIDTH +: WIDTH];
               b_sh_d  = bus.op_b[int'(winner)*WIDTH +: WIDTH];
               sel_d   = bus.op_sel[winner];
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_sh_d            = a_sh_q >> 1;
            b_sh_d            = b_sh_q >> 1;
            acc_d             = acc_q >> 1;
            acc_d[WIDTH-1]    = slice_bit;
            cnt_d             = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               result_d  = acc_d;
               done_id_d = ptr_q;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         ptr_q     <= PTR_RST;
         done_id_q <= '0;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         acc_q     <= '0;
         result_q  <= '0;
         sel_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         done_id_q <= done_id_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.done_id = done_id_q;
   assign bus.result  = result_q;
endmodule

// File: tb/tb_mux_gate_arbiter.sv
// tb/tb_mux_gate_arbiter.sv - scoreboard bench for mux_gate_arbiter (WIDTH=8 and WIDTH=1 builds)
module tb_mux_gate_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   typedef struct {
      int           id;
      logic [W-1:0] res;
      int           due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_gate_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
   mux_gate_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   mux_gate_arbiter_if #(.NUM_REQ(2), .WIDTH(1)) bus1 ();
   mux_gate_arbiter #(.NUM_REQ(2), .WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int n_checks = 0;
   int n_fail   = 0;

   exp_t sbq[$];
   exp_t me, se;
   int   cyc = 0;
   int   m_busy, m_ptr, mw;
   logic [N-1:0] m_grant;
   logic [W-1:0] ma, mb;
   logic         ms;

   logic         seen_done = 1'b0;
   int           seen_id   = 0;
   logic [W-1:0] seen_res  = '0;
   int           seen_cyc  = 0;
   int           exp_ids[5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic note_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s actual=missing required=present", nm);
   endtask

   // Reference model: transaction-level RR arbiter with a fixed WIDTH+2 issue interval.
   initial begin
      m_ptr   = N - 1;
      m_busy  = 0;
      m_grant = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_ptr   = N - 1;
            m_busy  = 0;
            m_grant = '0;
            sbq.delete();
         end else begin
            cyc++;
            if (m_busy > 0) begin
               m_busy--;
               if (m_busy == 0) m_grant = '0;
            end else if (bus.req != '0) begin
               mw = -1;
               for (int k = 1; k <= N; k++)
                  if (mw < 0 && bus.req[(m_ptr + k) % N]) mw = (m_ptr + k) % N;
               m_ptr       = mw;
               m_grant     = '0;
               m_grant[mw] = 1'b1;
               ma          = bus.op_a[mw*W +: W];
               mb          = bus.op_b[mw*W +: W];
               ms          = bus.op_sel[mw];
               me.id       = mw;
               me.res      = ms ? ~(ma ^ mb) : (ma ^ mb);
               me.due      = cyc + W;
               sbq.push_back(me);
               m_busy      = W + 1;
            end
         end
      end
   end

   // Monitor: checks grant/busy every cycle and pops the scoreboard on each done.
   initial begin
      forever begin
         @(negedge clk);
         chk("grant", bus.grant, m_grant);
         chk("busy", bus.busy, |m_grant);
         if (bus.done) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               se = sbq.pop_front();
               chk("done_id", bus.done_id, se.id);
               chk("result", bus.result, se.res);
               chk("done_cycle", cyc, se.due);
            end
         end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            note_fail("done_timeout");
            se = sbq.pop_front();
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic drive_cycle(input int p_raise);
      logic [N-1:0] dm;
      @(negedge clk);
      dm        = '0;
      seen_done = bus.done;
      if (bus.done) begin
         dm[bus.done_id] = 1'b1;
         seen_id  = int'(bus.done_id);
         seen_res = bus.result;
         seen_cyc = cyc;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (dm[i]) begin
            bus.req[i] = 1'b0;
         end else if (!bus.req[i] && int'($urandom_range(99)) < p_raise) begin
            bus.op_a[i*W +: W] = W'($urandom);
            bus.op_b[i*W +: W] = W'($urandom);
            bus.op_sel[i]      = 1'($urandom_range(1));
            bus.req[i]         = 1'b1;
         end
      end
   endtask

   task automatic wait_done(input int id, input int maxc);
      bit got = 1'b0;
      for (int c = 0; c < maxc && !got; c++) begin
         drive_cycle(0);
         if (seen_done && seen_id == id) got = 1'b1;
      end
      if (!got) note_fail("wait_done");
   endtask

   task automatic drain();
      bit idle = 1'b0;
      for (int c = 0; c < 300 && !idle; c++) begin
         drive_cycle(0);
         if (bus.req == '0 && sbq.size() == 0 && !bus.busy) idle = 1'b1;
      end
      if (!idle) note_fail("drain");
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.req = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      bus.op_a[i*W +: W] = a;
      bus.op_b[i*W +: W] = b;
      bus.op_sel[i]      = s;
   endtask

   initial begin
      logic [3:0] w1_tab [4];
      int got, prev;
      bus.req     = '0;
      bus.op_a    = '0;
      bus.op_b    = '0;
      bus.op_sel  = '0;
      bus1.req    = '0;
      bus1.op_a   = '0;
      bus1.op_b   = '0;
      bus1.op_sel = '0;
      exp_ids     = '{0, 1, 2, 3, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", bus.grant, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_done_id", bus.done_id, 0);
      chk("rst_result", bus.result, 0);
      rst_n = 1'b1;

      // XOR / XNOR on requester 0
      set_op(0, 8'hA5, 8'h3C, 1'b0);
      bus.req = 4'b0001;
      @(posedge clk);
      #1;
      chk("t1_grant", bus.grant, 4'b0001);
      wait_done(0, 30);
      chk("t1_result", seen_res, 8'h99);
      drive_cycle(0);
      set_op(0, 8'hA5, 8'h3C, 1'b1);
      bus.req[0] = 1'b1;
      wait_done(0, 30);
      chk("t2_xnor", seen_res, 8'h66);
      drive_cycle(0);
      set_op(0, 8'hFF, 8'h00, 1'b1);
      bus.req[0] = 1'b1;
      wait_done(0, 30);
      chk("t2_ff00", seen_res, 8'h00);

      // All four requesting: strict round robin, one done every WIDTH+2 cycles
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom), 1'($urandom_range(1)));
      bus.req = 4'b1111;
      got  = 0;
      prev = -1;
      for (int c = 0; c < 200 && got < 5; c++) begin
         drive_cycle(100);
         if (seen_done) begin
            chk("t3_order", seen_id, exp_ids[got]);
            if (prev >= 0) chk("t3_interval", seen_cyc - prev, W + 2);
            prev = seen_cyc;
            got++;
         end
      end
      if (got < 5) note_fail("t3_dones");
      bus.req = '0;
      drain();

      // Operand and req changes during SHIFT are ignored
      set_op(1, 8'h0F, 8'hF0, 1'b0);
      bus.req = 4'b0010;
      @(posedge clk);
      #1;
      chk("t4_grant", bus.grant, 4'b0010);
      repeat (3) @(posedge clk);
      #1;
      set_op(1, 8'hFF, 8'h00, 1'b1);
      bus.req = '0;
      wait_done(1, 30);
      chk("t4_captured", seen_res, 8'hFF);
      drain();

      // Reset in the middle of SHIFT
      set_op(0, 8'h5A, 8'hC3, 1'b0);
      bus.req = 4'b0001;
      repeat (6) @(posedge clk);
      #1;
      rst_n   = 1'b0;
      bus.req = '0;
      #1;
      chk("t5_grant", bus.grant, 0);
      chk("t5_busy", bus.busy, 0);
      chk("t5_done", bus.done, 0);
      chk("t5_result", bus.result, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_op(2, 8'h12, 8'h34, 1'b0);
      bus.req = 4'b0100;
      @(posedge clk);
      #1;
      chk("t5_regrant", bus.grant, 4'b0100);
      wait_done(2, 30);
      chk("t5_id", seen_id, 2);
      chk("t5_res", seen_res, 8'h26);
      drain();

      // Randomised traffic against the reference model
      for (int c = 0; c < 500; c++) drive_cycle(25);
      drain();

      // WIDTH=1 build: {a, b, sel, expected}
      w1_tab = '{4'b1100, 4'b1001, 4'b1111, 4'b0110};
      for (int t = 0; t < 4; t++) begin
         bus1.op_a   = {1'b0, w1_tab[t][3]};
         bus1.op_b   = {1'b0, w1_tab[t][2]};
         bus1.op_sel = {1'b0, w1_tab[t][1]};
         bus1.req    = 2'b01;
         @(posedge clk);
         #1;
         chk("w1_grant", bus1.grant, 2'b01);
         chk("w1_no_done_yet", bus1.done, 0);
         @(posedge clk);
         #1;
         chk("w1_done", bus1.done, 1);
         chk("w1_result", bus1.result, w1_tab[t][0]);
         chk("w1_done_id", bus1.done_id, 0);
         bus1.req = '0;
         @(posedge clk);
         #1;
         chk("w1_done_pulse", bus1.done, 0);
         chk("w1_grant_clr", bus1.grant, 0);
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
